// File: rtl/osd_vram_wr_queue.sv
// CPU-to-VRAM write queue for the OSD character generator: edge-detected commands,
// auto-increment pointer, block-fill engine and a FIFO drained during blanking.
module osd_vram_wr_queue #(
    parameter int C_AW         = 10,
    parameter int C_DW         = 8,
    parameter int C_FIFO_DEPTH = 16,
    parameter int C_FILL_W     = 10
) (
    input  logic                            CK_i,
    input  logic                            SYS_R_i,
    input  logic                            CMD_WE_i,
    input  logic [1:0]                      CMD_MODE_i,
    input  logic [C_AW-1:0]                 CMD_AD_i,
    input  logic [C_DW-1:0]                 CMD_WD_i,
    input  logic [C_FILL_W-1:0]             FILL_LEN_i,
    input  logic                            BLANK_i,
    input  logic                            FORCE_i,
    input  logic                            OVF_CLR_i,
    output logic [C_AW-1:0]                 VRAM_WAs_o,
    output logic [C_DW-1:0]                 VRAM_WDs_o,
    output logic                            VRAM_WE_o,
    output logic                            BUSY_o,
    output logic                            FULL_o,
    output logic [$clog2(C_FIFO_DEPTH):0]   LEVEL_o,
    output logic                            OVF_o
);

    localparam int C_PW = $clog2(C_FIFO_DEPTH);
    localparam int C_EW = C_AW + C_DW;
    localparam logic [C_PW:0] DEPTH_CNT = (C_PW + 1)'(C_FIFO_DEPTH);

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_INC    = 2'd1;
    localparam logic [1:0] MODE_PTR    = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    logic                cmd_prev;
    logic                cmd_det;
    logic                cmd_accept;
    logic                cmd_push_req;
    logic [C_AW-1:0]     ptr;
    logic [C_AW-1:0]     fill_ptr;
    logic [C_FILL_W-1:0] fill_cnt;
    logic [C_DW-1:0]     fill_wd;
    logic                fill_active;
    logic                fill_push;

    logic [C_EW-1:0]     mem [C_FIFO_DEPTH];
    logic [C_PW-1:0]     wr_idx;
    logic [C_PW-1:0]     rd_idx;
    logic [C_PW:0]       count;
    logic                empty;
    logic                full;
    logic                pop;
    logic                slot_free;
    logic                push;
    logic [C_EW-1:0]     push_entry;
    logic                ovf_set;

    always_comb begin
        cmd_det      = CMD_WE_i & ~cmd_prev;
        empty        = (count == '0);
        full         = (count == DEPTH_CNT);
        fill_active  = (fill_cnt != '0);
        pop          = ~empty & (BLANK_i | FORCE_i);
        slot_free    = ~full | pop;
        cmd_accept   = cmd_det & ~fill_active;
        cmd_push_req = cmd_accept & ((CMD_MODE_i == MODE_SINGLE) | (CMD_MODE_i == MODE_INC));

        push       = 1'b0;
        fill_push  = 1'b0;
        push_entry = {fill_ptr, fill_wd};
        if (cmd_push_req) begin
            push       = slot_free;
            push_entry = {(CMD_MODE_i == MODE_INC) ? ptr : CMD_AD_i, CMD_WD_i};
        end else if (fill_active && slot_free) begin
            push      = 1'b1;
            fill_push = 1'b1;
        end

        // Commands during a fill are rejected; the fill itself only ever stalls.
        ovf_set = (cmd_det & fill_active) | (cmd_push_req & ~slot_free);
    end

    always_ff @(posedge CK_i) begin
        if (SYS_R_i) begin
            cmd_prev   <= 1'b1;
            ptr        <= '0;
            fill_ptr   <= '0;
            fill_cnt   <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            count      <= '0;
            VRAM_WE_o  <= 1'b0;
            VRAM_WAs_o <= '0;
            VRAM_WDs_o <= '0;
            OVF_o      <= 1'b0;
        end else begin
            cmd_prev <= CMD_WE_i;

            if (cmd_accept && CMD_MODE_i == MODE_PTR) begin
                ptr <= CMD_AD_i;
            end else if (cmd_accept && CMD_MODE_i == MODE_INC) begin
                ptr <= ptr + 1'b1;
            end

            if (cmd_accept && CMD_MODE_i == MODE_FILL) begin
                fill_ptr <= CMD_AD_i;
                fill_cnt <= FILL_LEN_i;
            end else if (fill_push) begin
                fill_ptr <= fill_ptr + 1'b1;
                fill_cnt <= fill_cnt - 1'b1;
            end

            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            VRAM_WE_o <= pop;
            if (pop) begin
                {VRAM_WAs_o, VRAM_WDs_o} <= mem[rd_idx];
            end

            if (ovf_set) begin
                OVF_o <= 1'b1;
            end else if (OVF_CLR_i) begin
                OVF_o <= 1'b0;
            end
        end
    end

    // Storage and fill data need no reset; occupancy and fill_cnt gate their use.
    always_ff @(posedge CK_i) begin
        if (push) begin
            mem[wr_idx] <= push_entry;
        end
        if (cmd_accept && CMD_MODE_i == MODE_FILL) begin
            fill_wd <= CMD_WD_i;
        end
    end

    assign BUSY_o  = ~empty | fill_active;
    assign FULL_o  = full;
    assign LEVEL_o = count;

endmodule

// File: tb/tb_osd_vram_wr_queue.sv
// Directed bench for osd_vram_wr_queue: each task drives one scenario and checks inline;
// a negedge monitor logs every VRAM write for order/content checks.
module tb_osd_vram_wr_queue;

    logic        CK_i = 1'b0;
    logic        SYS_R_i;
    logic        CMD_WE_i;
    logic [1:0]  CMD_MODE_i;
    logic [9:0]  CMD_AD_i;
    logic [7:0]  CMD_WD_i;
    logic [9:0]  FILL_LEN_i;
    logic        BLANK_i;
    logic        FORCE_i;
    logic        OVF_CLR_i;
    logic [9:0]  VRAM_WAs_o;
    logic [7:0]  VRAM_WDs_o;
    logic        VRAM_WE_o;
    logic        BUSY_o;
    logic        FULL_o;
    logic [4:0]  LEVEL_o;
    logic        OVF_o;

    int total = 0;
    int bad   = 0;

    logic [9:0] wa_q[$];
    logic [7:0] wd_q[$];

    osd_vram_wr_queue #(.C_AW(10), .C_DW(8), .C_FIFO_DEPTH(16), .C_FILL_W(10)) dut (
        .CK_i(CK_i), .SYS_R_i(SYS_R_i), .CMD_WE_i(CMD_WE_i), .CMD_MODE_i(CMD_MODE_i),
        .CMD_AD_i(CMD_AD_i), .CMD_WD_i(CMD_WD_i), .FILL_LEN_i(FILL_LEN_i),
        .BLANK_i(BLANK_i), .FORCE_i(FORCE_i), .OVF_CLR_i(OVF_CLR_i),
        .VRAM_WAs_o(VRAM_WAs_o), .VRAM_WDs_o(VRAM_WDs_o), .VRAM_WE_o(VRAM_WE_o),
        .BUSY_o(BUSY_o), .FULL_o(FULL_o), .LEVEL_o(LEVEL_o), .OVF_o(OVF_o)
    );

    always #5 CK_i = ~CK_i;

    always @(negedge CK_i) begin
        if (VRAM_WE_o === 1'b1) begin
            wa_q.push_back(VRAM_WAs_o);
            wd_q.push_back(VRAM_WDs_o);
        end
    end

    task automatic tick();
        @(posedge CK_i);
        #1;
    endtask

    // Strobe rises at the first edge (command detected there), falls before the second.
    task automatic issue(input logic [1:0] mode, input logic [9:0] ad, input logic [7:0] wd,
                         input logic [9:0] len);
        CMD_MODE_i = mode;
        CMD_AD_i   = ad;
        CMD_WD_i   = wd;
        FILL_LEN_i = len;
        CMD_WE_i   = 1'b1;
        tick();
        CMD_WE_i   = 1'b0;
        tick();
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset();
        SYS_R_i = 1'b1;
        tick();
        tick();
        total++;
        if ({VRAM_WAs_o, VRAM_WDs_o, VRAM_WE_o, BUSY_o, FULL_o, LEVEL_o, OVF_o} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs got wa=%h wd=%h we=%b busy=%b full=%b lvl=%0d ovf=%b want all 0",
                     VRAM_WAs_o, VRAM_WDs_o, VRAM_WE_o, BUSY_o, FULL_o, LEVEL_o, OVF_o);
        end
        SYS_R_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        clear_log();
        BLANK_i    = 1'b1;
        CMD_MODE_i = 2'd0;
        CMD_AD_i   = 10'h123;
        CMD_WD_i   = 8'h5A;
        CMD_WE_i   = 1'b1;
        tick();
        total++;
        if (LEVEL_o !== 5'd1 || VRAM_WE_o !== 1'b0 || BUSY_o !== 1'b1) begin
            bad++;
            $display("FAIL single_edge_k got lvl=%0d we=%b busy=%b want lvl=1 we=0 busy=1",
                     LEVEL_o, VRAM_WE_o, BUSY_o);
        end
        CMD_WE_i = 1'b0;
        tick();
        total++;
        if (VRAM_WE_o !== 1'b1 || VRAM_WAs_o !== 10'h123 || VRAM_WDs_o !== 8'h5A || BUSY_o !== 1'b0) begin
            bad++;
            $display("FAIL single_write got we=%b wa=%h wd=%h busy=%b want we=1 wa=123 wd=5a busy=0",
                     VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o, BUSY_o);
        end
        tick();
        total++;
        if (VRAM_WE_o !== 1'b0 || wa_q.size() != 1) begin
            bad++;
            $display("FAIL single_pulse got we=%b writes=%0d want we=0 writes=1", VRAM_WE_o, wa_q.size());
        end
    endtask

    task automatic test_autoinc();
        logic [9:0] exp_a [3];
        exp_a[0] = 10'h3FE;
        exp_a[1] = 10'h3FF;
        exp_a[2] = 10'h000;
        clear_log();
        BLANK_i = 1'b1;
        issue(2'd2, 10'h3FE, 8'h00, 10'd0);
        for (int i = 1; i <= 3; i++) issue(2'd1, 10'h055, 8'(i), 10'd0);
        tick();
        tick();
        total++;
        if (wa_q.size() != 3) begin
            bad++;
            $display("FAIL autoinc_count got %0d want 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wa_q[i] !== exp_a[i] || wd_q[i] !== 8'(i + 1)) begin
                    bad++;
                    $display("FAIL autoinc_%0d got wa=%h wd=%h want wa=%h wd=%h",
                             i, wa_q[i], wd_q[i], exp_a[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_gated();
        clear_log();
        BLANK_i = 1'b0;
        FORCE_i = 1'b0;
        for (int i = 0; i < 16; i++) issue(2'd0, 10'h200 + 10'(i), 8'h40 + 8'(i), 10'd0);
        total++;
        if (LEVEL_o !== 5'd16 || FULL_o !== 1'b1 || wa_q.size() != 0 || OVF_o !== 1'b0) begin
            bad++;
            $display("FAIL gated_fill got lvl=%0d full=%b writes=%0d ovf=%b want 16 1 0 0",
                     LEVEL_o, FULL_o, wa_q.size(), OVF_o);
        end
        issue(2'd0, 10'h2FF, 8'hEE, 10'd0);
        total++;
        if (OVF_o !== 1'b1 || LEVEL_o !== 5'd16) begin
            bad++;
            $display("FAIL gated_overflow got ovf=%b lvl=%0d want ovf=1 lvl=16", OVF_o, LEVEL_o);
        end
        BLANK_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (VRAM_WE_o !== 1'b1 || VRAM_WAs_o !== 10'h200 + 10'(i) || VRAM_WDs_o !== 8'h40 + 8'(i)) begin
                bad++;
                $display("FAIL gated_drain_%0d got we=%b wa=%h wd=%h want we=1 wa=%h wd=%h",
                         i, VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o, 10'h200 + 10'(i), 8'h40 + 8'(i));
            end
        end
        tick();
        total++;
        if (VRAM_WE_o !== 1'b0 || LEVEL_o !== 5'd0 || FULL_o !== 1'b0 || BUSY_o !== 1'b0) begin
            bad++;
            $display("FAIL gated_empty got we=%b lvl=%0d full=%b busy=%b want 0 0 0 0",
                     VRAM_WE_o, LEVEL_o, FULL_o, BUSY_o);
        end
        OVF_CLR_i = 1'b1;
        tick();
        OVF_CLR_i = 1'b0;
        total++;
        if (OVF_o !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got %b want 0", OVF_o);
        end
    endtask

    task automatic check_fill(input string name, input logic [9:0] base, input logic [7:0] wd,
                              input logic exp_ovf);
        total++;
        if (wa_q.size() != 40 || OVF_o !== exp_ovf) begin
            bad++;
            $display("FAIL %s_count got writes=%0d ovf=%b want writes=40 ovf=%b",
                     name, wa_q.size(), OVF_o, exp_ovf);
        end else begin
            for (int i = 0; i < 40; i++) begin
                if (wa_q[i] !== base + 10'(i) || wd_q[i] !== wd) begin
                    total++;
                    bad++;
                    $display("FAIL %s_entry_%0d got wa=%h wd=%h want wa=%h wd=%h",
                             name, i, wa_q[i], wd_q[i], base + 10'(i), wd);
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY_o !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got busy=%b want 0 within 300 cycles", name, BUSY_o);
        end
        tick();
        tick();
    endtask

    task automatic test_fill();
        clear_log();
        BLANK_i = 1'b1;
        issue(2'd3, 10'h100, 8'h20, 10'd40);
        issue(2'd0, 10'h3AA, 8'hBB, 10'd0);
        wait_idle("fill");
        check_fill("fill", 10'h100, 8'h20, 1'b1);
        OVF_CLR_i = 1'b1;
        tick();
        OVF_CLR_i = 1'b0;
    endtask

    task automatic test_fill_zero();
        clear_log();
        BLANK_i    = 1'b1;
        CMD_MODE_i = 2'd3;
        CMD_AD_i   = 10'h050;
        CMD_WD_i   = 8'h11;
        FILL_LEN_i = 10'd0;
        CMD_WE_i   = 1'b1;
        tick();
        total++;
        if (BUSY_o !== 1'b0) begin
            bad++;
            $display("FAIL fill_zero_busy got %b want 0", BUSY_o);
        end
        CMD_WE_i = 1'b0;
        tick();
        tick();
        total++;
        if (BUSY_o !== 1'b0 || wa_q.size() != 0) begin
            bad++;
            $display("FAIL fill_zero_writes got busy=%b writes=%0d want 0 0", BUSY_o, wa_q.size());
        end
    endtask

    task automatic test_fill_stall();
        int n = 0;
        clear_log();
        BLANK_i = 1'b0;
        issue(2'd3, 10'h3F0, 8'hA5, 10'd40);
        while (BUSY_o !== 1'b0 && n < 400) begin
            if (n % 5 == 0) BLANK_i = ~BLANK_i;
            tick();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL stall_timeout got busy=%b want 0 within 400 cycles", BUSY_o);
        end
        BLANK_i = 1'b1;
        tick();
        tick();
        check_fill("stall", 10'h3F0, 8'hA5, 1'b0);
    endtask

    task automatic test_reset_mid();
        clear_log();
        BLANK_i = 1'b0;
        for (int i = 0; i < 8; i++) issue(2'd0, 10'h080 + 10'(i), 8'(i), 10'd0);
        total++;
        if (LEVEL_o !== 5'd8) begin
            bad++;
            $display("FAIL reset_mid_level got %0d want 8", LEVEL_o);
        end
        CMD_MODE_i = 2'd0;
        CMD_WE_i   = 1'b1;
        SYS_R_i    = 1'b1;
        tick();
        total++;
        if ({VRAM_WAs_o, VRAM_WDs_o, VRAM_WE_o, BUSY_o, FULL_o, LEVEL_o, OVF_o} !== 25'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs got wa=%h wd=%h we=%b busy=%b full=%b lvl=%0d ovf=%b want all 0",
                     VRAM_WAs_o, VRAM_WDs_o, VRAM_WE_o, BUSY_o, FULL_o, LEVEL_o, OVF_o);
        end
        SYS_R_i = 1'b0;
        BLANK_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (wa_q.size() != 0 || LEVEL_o !== 5'd0 || BUSY_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_spurious got writes=%0d lvl=%0d busy=%b want 0 0 0",
                     wa_q.size(), LEVEL_o, BUSY_o);
        end
        // Pointer was reset, so an auto-increment write now lands at address 0.
        CMD_WE_i = 1'b0;
        tick();
        issue(2'd1, 10'h1FF, 8'h77, 10'd0);
        tick();
        total++;
        if (wa_q.size() != 1 || wa_q[0] !== 10'h000 || wd_q[0] !== 8'h77) begin
            bad++;
            $display("FAIL reset_mid_after got writes=%0d first_wa=%h first_wd=%h want 1 000 77",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 10'h3FF,
                     (wd_q.size() > 0) ? wd_q[0] : 8'hFF);
        end
    endtask

    initial begin
        SYS_R_i    = 1'b1;
        CMD_WE_i   = 1'b0;
        CMD_MODE_i = 2'd0;
        CMD_AD_i   = '0;
        CMD_WD_i   = '0;
        FILL_LEN_i = '0;
        BLANK_i    = 1'b0;
        FORCE_i    = 1'b0;
        OVF_CLR_i  = 1'b0;
        test_reset();
        test_single();
        test_autoinc();
        test_gated();
        test_fill();
        test_fill_zero();
        test_fill_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/osd_vram_wr_queue.md
# osd_vram_wr_queue

Parametrised CPU-to-VRAM write queue for the OSD character generator. It accepts write commands from CPU-mapped register bits and buffers them in a FIFO. It drains them into the character VRAM write port only while the video is blanking, or when the CPU has forced VRAM ownership. It adds auto-increment addressing, hardware block fill, and overflow reporting, none of which a raw register-to-VRAM write path provides.

## Interface
- C_AW, 10: VRAM address width.
- C_DW, 8: VRAM data width.
- C_FIFO_DEPTH, 16: FIFO entries; power of two, at least 2.
- C_FILL_W, 10: fill-length counter width.

- CK_i  in  1  system clock; all logic on its rising edge.
- SYS_R_i  in  1  reset, synchronous, active-high.
- CMD_WE_i  in  1  command strobe level from a CPU register bit; a 0→1 transition issues one command.
- CMD_MODE_i  in  2  0 single write; 1 auto-increment write; 2 set pointer; 3 block fill.
- CMD_AD_i  in  C_AW  address for modes 0, 2 and 3.
- CMD_WD_i  in  C_DW  write data or fill data.
- FILL_LEN_i  in  C_FILL_W  number of fill writes for mode 3.
- BLANK_i  in  1  video blanking; enables drain.
- FORCE_i  in  1  CPU owns VRAM; enables drain regardless of BLANK_i.
- OVF_CLR_i  in  1  clears OVF_o.
- VRAM_WAs_o  out  C_AW  VRAM write address (registered).
- VRAM_WDs_o  out  C_DW  VRAM write data (registered).
- VRAM_WE_o  out  1  VRAM write enable; one-cycle pulse per entry.
- BUSY_o  out  1  FIFO non-empty, or fill active.
- FULL_o  out  1  FIFO holds C_FIFO_DEPTH entries.
- LEVEL_o  out  log2(C_FIFO_DEPTH)+1  FIFO occupancy.
- OVF_o  out  1  sticky flag: a command or entry was lost.

## Operation

**Command detect**
- A command is detected at edge k when CMD_WE_i = 1 is sampled at k and the previous sample was 0.
- CMD_* inputs are captured at that same edge k.
- Reset sets the previous-sample register to 1. A strobe held high through reset therefore issues no command.

**Command modes**
- Mode 0: push {CMD_AD_i, CMD_WD_i}.
- Mode 1: push {PTR, CMD_WD_i}, then PTR ← PTR+1, wrapping modulo 2^C_AW.
- Mode 2: PTR ← CMD_AD_i. Nothing is pushed.
- Mode 3:
  - Load FILL_PTR ← CMD_AD_i, FILL_CNT ← FILL_LEN_i, FILL_WD ← CMD_WD_i.
  - The fill engine is active while FILL_CNT ≠ 0. FILL_LEN_i = 0 completes immediately with no writes.
  - While active, it pushes {FILL_PTR, FILL_WD} once per cycle whenever a push slot is free.
  - Each push does FILL_PTR+1 (with wrap) and FILL_CNT−1.

**Overflow and rejection**
- A command detected while the fill engine is active is discarded and sets OVF_o. This applies to all modes, including mode 2.
- A push slot is free when FIFO not full, or a pop occurs in the same cycle.
- A mode-0 or mode-1 push with no free slot is discarded and sets OVF_o. In mode 1, PTR is still incremented.
- The fill engine never overflows; it stalls instead.

**Drain**
- Each cycle with FIFO non-empty and (BLANK_i | FORCE_i) = 1, pop one entry.
- At the next edge, VRAM_WAs_o/VRAM_WDs_o take the popped entry and VRAM_WE_o = 1. Otherwise VRAM_WE_o = 0 and address/data hold.
- Entries drain in FIFO order.

**OVF_o**
- Set has priority over OVF_CLR_i in the same cycle.

## Timing
- Reset values:
  - VRAM_WAs_o = 0, VRAM_WDs_o = 0, VRAM_WE_o = 0.
  - BUSY_o = 0, FULL_o = 0, LEVEL_o = 0, OVF_o = 0.
  - PTR = 0, fill engine idle, FIFO empty.
- Reset mid-operation discards all queued entries and any remaining fill.
- Latency, with drain enabled: command detected at edge k → entry in FIFO after k → VRAM_WE_o high after edge k+1.
- First fill push occurs at edge k+1 after a mode-3 command at edge k.
- Sustained throughput is one VRAM write per clock.
- LEVEL_o and FULL_o reflect occupancy after each edge.
- A simultaneous push and pop leaves LEVEL_o unchanged.
- BUSY_o falls at the edge where the last entry is popped and the fill engine is idle. VRAM_WE_o may be high in that same cycle.
- Drain enable dropping stops pops at the next edge. An entry already registered still completes its VRAM_WE_o pulse.

## Test plan
- **Single write:** BLANK_i=1; mode 0, AD=0x123, WD=0x5A, strobe 0→1 at edge k → VRAM_WE_o=1 for exactly one cycle after edge k+1, WAs=0x123, WDs=0x5A; BUSY_o back to 0.
- **Auto-increment:** mode 2 AD=0x3FE, then three mode-1 writes WD=1,2,3 → VRAM writes at 0x3FE, 0x3FF, 0x000 with data 1, 2, 3.
- **Gated drain:** BLANK_i=0, FORCE_i=0; 16 mode-0 writes → LEVEL_o=16, FULL_o=1, no VRAM_WE_o. A 17th write → OVF_o=1, LEVEL_o stays 16. Raise BLANK_i → 16 consecutive VRAM_WE_o pulses in order. OVF_CLR_i → OVF_o=0.
- **Block fill:** mode 3, AD=0x100, LEN=40, WD=0x20, BLANK_i=1 → exactly 40 writes, addresses 0x100..0x127, all data 0x20. A mode-0 command issued mid-fill → discarded, OVF_o=1.
- **Edge cases:** fill with LEN=0 → no writes, BUSY_o stays 0. Fill with BLANK_i toggled every 5 cycles → stalls with no loss, total of 40 writes.
- **Reset:** SYS_R_i asserted with 8 entries queued and CMD_WE_i held 1 → all outputs at reset values; after release, no VRAM_WE_o and no spurious command until CMD_WE_i goes 0→1.
